// File: rtl/exe_stage_if.sv
// rtl/exe_stage_if.sv - ID/EX inputs and EX/MEM outputs of the execute stage
interface exe_stage_if;
  // Pipeline inputs from the ID/EX register
  logic        freeze;
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic        b_in;
  logic        s_in;
  logic [3:0]  exe_cmd_in;
  logic [31:0] pc_in;
  logic [31:0] val_rn_in;
  logic [31:0] val_rm_in;
  logic        imm_in;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [3:0]  dest_in;

  // Branch resolution and EX/MEM outputs
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [3:0]  status;
  logic        wb_en;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] alu_res;
  logic [31:0] val_rm;
  logic [3:0]  dest;

  modport master (
    output freeze, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd_in,
           pc_in, val_rn_in, val_rm_in, imm_in, shift_operand, signed_imm_24, dest_in,
    input  branch_taken, branch_addr, status, wb_en, mem_r_en, mem_w_en,
           alu_res, val_rm, dest
  );

  modport slave (
    input  freeze, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd_in,
           pc_in, val_rn_in, val_rm_in, imm_in, shift_operand, signed_imm_24, dest_in,
    output branch_taken, branch_addr, status, wb_en, mem_r_en, mem_w_en,
           alu_res, val_rm, dest
  );
endinterface

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: operand-2 generation, ALU, NZCV and EX/MEM register
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  exe_stage_if.slave  bus
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  // EX/MEM boundary and status register
  logic        wb_en_q, wb_en_d;
  logic        mem_r_en_q, mem_r_en_d;
  logic        mem_w_en_q, mem_w_en_d;
  logic [31:0] alu_res_q, alu_res_d;
  logic [31:0] val_rm_q, val_rm_d;
  logic [3:0]  dest_q, dest_d;
  logic [3:0]  status_q, status_d;

  logic [31:0] val2;
  logic [31:0] res;
  logic        flag_c;
  logic        flag_v;

  // The carry input is the C flag of the registered status ({N,Z,C,V})
  logic        c_in;
  assign c_in = status_q[1];

  // Operand 2: memory offset, rotated 8-bit immediate, or shifted Rm
  logic [4:0]  imm_rot;
  logic [63:0] imm_dbl;
  logic [4:0]  sh_amt;
  logic [63:0] rm_dbl;
  always_comb begin
    imm_rot = {bus.shift_operand[11:8], 1'b0};
    imm_dbl = {2{24'b0, bus.shift_operand[7:0]}} >> imm_rot;
    sh_amt  = bus.shift_operand[11:7];
    rm_dbl  = {bus.val_rm_in, bus.val_rm_in} >> sh_amt;
    val2    = 32'b0;
    if (bus.mem_r_en_in || bus.mem_w_en_in) begin
      val2 = {20'b0, bus.shift_operand};
    end else if (bus.imm_in) begin
      val2 = imm_dbl[31:0];
    end else begin
      unique case (bus.shift_operand[6:5])
        2'b00:   val2 = bus.val_rm_in << sh_amt;
        2'b01:   val2 = bus.val_rm_in >> sh_amt;
        2'b10:   val2 = $unsigned($signed(bus.val_rm_in) >>> sh_amt);
        default: val2 = rm_dbl[31:0];
      endcase
    end
  end

  // ALU: one shared adder serves ADD/ADC/SUB/SBC by inverting operand 2 for subtraction
  logic        is_arith;
  logic        is_sub;
  logic        add_cin;
  logic [31:0] b_eff;
  logic [32:0] sum;
  always_comb begin
    is_arith = 1'b0;
    is_sub   = 1'b0;
    add_cin  = 1'b0;
    res      = 32'b0;
    flag_c   = status_q[1];
    flag_v   = status_q[0];
    unique case (bus.exe_cmd_in)
      CMD_ADD: is_arith = 1'b1;
      CMD_ADC: begin is_arith = 1'b1; add_cin = c_in; end
      CMD_SUB: begin is_arith = 1'b1; is_sub = 1'b1; add_cin = 1'b1; end
      CMD_SBC: begin is_arith = 1'b1; is_sub = 1'b1; add_cin = c_in; end
      default: ;
    endcase
    b_eff = is_sub ? ~val2 : val2;
    sum   = {1'b0, bus.val_rn_in} + {1'b0, b_eff} + {32'b0, add_cin};
    unique case (bus.exe_cmd_in)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_AND: res = bus.val_rn_in & val2;
      CMD_ORR: res = bus.val_rn_in | val2;
      CMD_EOR: res = bus.val_rn_in ^ val2;
      default: res = is_arith ? sum[31:0] : 32'b0;
    endcase
    // Subtraction carry is the adder carry-out, i.e. NOT borrow
    if (is_arith) begin
      flag_c = sum[32];
      flag_v = (bus.val_rn_in[31] == b_eff[31]) && (sum[31] != bus.val_rn_in[31]);
    end
  end

  // Next-state values for the EX/MEM register and status
  always_comb begin
    wb_en_d    = bus.wb_en_in;
    mem_r_en_d = bus.mem_r_en_in;
    mem_w_en_d = bus.mem_w_en_in;
    alu_res_d  = res;
    val_rm_d   = bus.val_rm_in;
    dest_d     = bus.dest_in;
    status_d   = bus.s_in ? {res[31], (res == 32'b0), flag_c, flag_v} : status_q;
  end

  // EX/MEM and status registers: cleared by reset, held while frozen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      alu_res_q  <= 32'b0;
      val_rm_q   <= 32'b0;
      dest_q     <= 4'b0;
      status_q   <= 4'b0;
    end else if (!bus.freeze) begin
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      mem_w_en_q <= mem_w_en_d;
      alu_res_q  <= alu_res_d;
      val_rm_q   <= val_rm_d;
      dest_q     <= dest_d;
      status_q   <= status_d;
    end
  end

  // Branch target is resolved combinationally from this cycle's inputs
  assign bus.branch_taken = bus.b_in;
  assign bus.branch_addr  = bus.pc_in + {{6{bus.signed_imm_24[23]}}, bus.signed_imm_24, 2'b00};

  assign bus.status   = status_q;
  assign bus.wb_en    = wb_en_q;
  assign bus.mem_r_en = mem_r_en_q;
  assign bus.mem_w_en = mem_w_en_q;
  assign bus.alu_res  = alu_res_q;
  assign bus.val_rm   = val_rm_q;
  assign bus.dest     = dest_q;

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - table, directed and randomized checks of exe_stage against a reference model
module tb_exe_stage;

  logic clk;
  logic rst;
  exe_stage_if bus ();

  exe_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        fr, wb, mr, mw, b, s;
    logic [3:0]  cmd;
    logic [31:0] pc, rn, rm;
    logic        imm;
    logic [11:0] so;
    logic [23:0] off;
    logic [3:0]  dest;
  } in_t;

  typedef struct packed {
    in_t         in;
    logic [31:0] exp_res;
    logic [3:0]  exp_st;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [3:0]  m_st;
  logic        m_wb, m_mr, m_mw;
  logic [31:0] m_res, m_rm;
  logic [3:0]  m_dest;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ror1(input logic [31:0] x, input int n);
    logic [31:0] y = x;
    for (int i = 0; i < n; i++) y = {y[0], y[31:1]};
    return y;
  endfunction

  function automatic logic [31:0] model_val2(input in_t v);
    int amt = int'(v.so[11:7]);
    logic [31:0] y = v.rm;
    if (v.mr || v.mw) return {20'b0, v.so};
    if (v.imm) return ror1({24'b0, v.so[7:0]}, 2 * int'(v.so[11:8]));
    case (v.so[6:5])
      2'd0: return v.rm << amt;
      2'd1: return v.rm >> amt;
      2'd2: begin
        for (int i = 0; i < amt; i++) y = {y[31], y[31:1]};
        return y;
      end
      default: return ror1(v.rm, amt);
    endcase
  endfunction

  // Result and flags from plain wide arithmetic
  task automatic model_alu(input in_t v, input logic [3:0] st,
                           output logic [31:0] res, output logic [3:0] nst);
    logic [31:0] v2 = model_val2(v);
    longint unsigned a = {32'b0, v.rn};
    longint unsigned b = {32'b0, v2};
    longint sa = $signed(v.rn);
    longint sb = $signed(v2);
    longint unsigned cin = {63'b0, st[1]};
    longint sr;
    logic c = st[1];
    logic ov = st[0];
    logic arith = 1'b1;
    longint unsigned full;
    case (v.cmd)
      4'b0010: begin full = a + b;       sr = sa + sb;              c = full >= 64'h1_0000_0000; end
      4'b0011: begin full = a + b + cin; sr = sa + sb + longint'(cin); c = full >= 64'h1_0000_0000; end
      4'b0100: begin full = a - b;       sr = sa - sb;              c = a >= b; end
      4'b0101: begin full = a - b - (1 - cin); sr = sa - sb - longint'(1 - cin); c = a >= b + (1 - cin); end
      default: begin arith = 1'b0; full = 0; sr = 0; end
    endcase
    if (arith) begin
      res = full[31:0];
      ov  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    end else begin
      case (v.cmd)
        4'b0001: res = v2;
        4'b1001: res = ~v2;
        4'b0110: res = v.rn & v2;
        4'b0111: res = v.rn | v2;
        4'b1000: res = v.rn ^ v2;
        default: res = 32'b0;
      endcase
    end
    nst = {res[31], res == 32'b0, c, ov};
  endtask

  task automatic model_reset();
    m_st = 4'b0; m_wb = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
    m_res = 32'b0; m_rm = 32'b0; m_dest = 4'b0;
  endtask

  task automatic drive(input in_t v);
    bus.freeze        = v.fr;
    bus.wb_en_in      = v.wb;
    bus.mem_r_en_in   = v.mr;
    bus.mem_w_en_in   = v.mw;
    bus.b_in          = v.b;
    bus.s_in          = v.s;
    bus.exe_cmd_in    = v.cmd;
    bus.pc_in         = v.pc;
    bus.val_rn_in     = v.rn;
    bus.val_rm_in     = v.rm;
    bus.imm_in        = v.imm;
    bus.shift_operand = v.so;
    bus.signed_imm_24 = v.off;
    bus.dest_in       = v.dest;
  endtask

  task automatic check_regs();
    chk("status", {28'b0, bus.status}, {28'b0, m_st});
    chk("alu_res", bus.alu_res, m_res);
    chk("val_rm", bus.val_rm, m_rm);
    chk("ctrl", {25'b0, bus.wb_en, bus.mem_r_en, bus.mem_w_en, bus.dest},
                {25'b0, m_wb, m_mr, m_mw, m_dest});
  endtask

  // Called at a negedge: drive, check branch outputs, clock once, check registers
  task automatic step(input in_t v);
    logic [31:0] r;
    logic [3:0]  ns;
    int          offw;
    drive(v);
    #1;
    offw = int'(v.off) - (v.off[23] ? 32'h0100_0000 : 0);
    chk("branch_taken", {31'b0, bus.branch_taken}, {31'b0, v.b});
    chk("branch_addr", bus.branch_addr, v.pc + 32'(offw * 4));
    model_alu(v, m_st, r, ns);
    if (!v.fr) begin
      m_wb = v.wb; m_mr = v.mr; m_mw = v.mw; m_res = r; m_rm = v.rm; m_dest = v.dest;
      if (v.s) m_st = ns;
    end
    @(negedge clk);
    check_regs();
  endtask

  function automatic in_t rand_in();
    in_t v;
    v.fr   = ($urandom_range(7) == 0);
    v.wb   = 1'($urandom);
    v.mr   = ($urandom_range(5) == 0);
    v.mw   = !v.mr && ($urandom_range(5) == 0);
    v.b    = 1'($urandom);
    v.s    = 1'($urandom);
    v.cmd  = 4'($urandom);
    v.pc   = $urandom;
    v.rn   = ($urandom_range(3) == 0) ? 32'h8000_0000 - 32'($urandom_range(2)) : $urandom;
    v.rm   = $urandom;
    v.imm  = 1'($urandom);
    v.so   = 12'($urandom);
    v.off  = 24'($urandom);
    v.dest = 4'($urandom);
    return v;
  endfunction

  function automatic vec_t mk(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                              input logic imm, input logic [11:0] so, input logic mr, input logic s,
                              input logic [31:0] er, input logic [3:0] es);
    vec_t t;
    t.in      = '0;
    t.in.wb   = !mr;
    t.in.mr   = mr;
    t.in.s    = s;
    t.in.cmd  = cmd;
    t.in.pc   = 32'h0000_0040;
    t.in.rn   = rn;
    t.in.rm   = rm;
    t.in.imm  = imm;
    t.in.so   = so;
    t.in.off  = 24'h000010;
    t.in.dest = cmd;
    t.exp_res = er;
    t.exp_st  = es;
    return t;
  endfunction

  vec_t tbl[17];
  in_t  v;
  logic [31:0] saved_res;
  logic [3:0]  saved_st;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk(4'b0010, 32'h7FFF_FFFF, 32'h0,         1'b1, 12'h001, 1'b0, 1'b1, 32'h8000_0000, 4'b1001);
    tbl[1]  = mk(4'b0100, 32'h5,         32'h0,         1'b1, 12'h005, 1'b0, 1'b1, 32'h0,         4'b0110);
    tbl[2]  = mk(4'b0011, 32'h1,         32'h0,         1'b1, 12'h001, 1'b0, 1'b0, 32'h3,         4'b0110);
    tbl[3]  = mk(4'b0001, 32'h0,         32'h0,         1'b1, 12'h4FF, 1'b0, 1'b0, 32'hFF00_0000, 4'b0110);
    tbl[4]  = mk(4'b0001, 32'h0,         32'h8000_0000, 1'b0, 12'h240, 1'b0, 1'b0, 32'hF800_0000, 4'b0110);
    tbl[5]  = mk(4'b1001, 32'h0,         32'h0,         1'b1, 12'h000, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b1010);
    tbl[6]  = mk(4'b0010, 32'h1000,      32'h0,         1'b1, 12'hFFF, 1'b1, 1'b0, 32'h0000_1FFF, 4'b1010);
    tbl[7]  = mk(4'b0110, 32'hF0F0,      32'h0F0F,      1'b0, 12'h000, 1'b0, 1'b1, 32'h0,         4'b0110);
    tbl[8]  = mk(4'b0101, 32'h5,         32'h0,         1'b1, 12'h003, 1'b0, 1'b1, 32'h2,         4'b0010);
    tbl[9]  = mk(4'b0111, 32'h1,         32'h2,         1'b0, 12'h080, 1'b0, 1'b1, 32'h5,         4'b0010);
    tbl[10] = mk(4'b1000, 32'hFFFF_FFFF, 32'h0,         1'b0, 12'h000, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b1010);
    tbl[11] = mk(4'b0100, 32'h0,         32'h0,         1'b1, 12'h001, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b1000);
    tbl[12] = mk(4'b0011, 32'hFFFF_FFFF, 32'h0,         1'b1, 12'h001, 1'b0, 1'b1, 32'h0,         4'b0110);
    tbl[13] = mk(4'b0000, 32'h1234,      32'h0,         1'b1, 12'h001, 1'b0, 1'b1, 32'h0,         4'b0110);
    tbl[14] = mk(4'b0001, 32'h0,         32'h8000_0000, 1'b0, 12'hFA0, 1'b0, 1'b0, 32'h1,         4'b0110);
    tbl[15] = mk(4'b0001, 32'h0,         32'h1234_5678, 1'b0, 12'h460, 1'b0, 1'b0, 32'h7812_3456, 4'b0110);
    tbl[16] = mk(4'b0101, 32'h8000_0000, 32'h0,         1'b1, 12'h001, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b0011);

    // Reset state
    rst = 1'b0;
    drive('0);
    model_reset();
    repeat (2) @(negedge clk);
    check_regs();
    rst = 1'b1;

    // Table vectors: hand-derived results and flags, plus model comparison
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].in);
      chk($sformatf("tbl%0d_res", i), bus.alu_res, tbl[i].exp_res);
      chk($sformatf("tbl%0d_st", i), {28'b0, bus.status}, {28'b0, tbl[i].exp_st});
    end

    // Freeze for three cycles with changing inputs, including a backward branch
    saved_res = m_res;
    saved_st  = m_st;
    for (int i = 0; i < 3; i++) begin
      v = rand_in();
      v.fr = 1'b1;
      v.s  = 1'b1;
      if (i == 1) begin v.b = 1'b1; v.pc = 32'h100; v.off = 24'hFFFFFE; end
      step(v);
      if (i == 1) begin
        chk("frz_branch_taken", {31'b0, bus.branch_taken}, 32'h1);
        chk("frz_branch_addr", bus.branch_addr, 32'h0000_00F8);
      end
    end
    chk("frz_alu_res", bus.alu_res, saved_res);
    chk("frz_status", {28'b0, bus.status}, {28'b0, saved_st});

    // Async reset pulse between edges with flags set
    v = tbl[0].in;
    step(v);
    chk("pre_rst_status", {28'b0, bus.status}, 32'h9);
    bus.freeze = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_alu_res", bus.alu_res, 32'h0);
    chk("async_rst_status", {28'b0, bus.status}, 32'h0);
    chk("async_rst_ctrl", {25'b0, bus.wb_en, bus.mem_r_en, bus.mem_w_en, bus.dest}, 32'h0);
    chk("async_rst_val_rm", bus.val_rm, 32'h0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    v = tbl[0].in;
    v.s = 1'b0;
    step(v);
    chk("post_rst_add_s0_status", {28'b0, bus.status}, 32'h0);
    chk("post_rst_add_res", bus.alu_res, 32'h8000_0000);

    // Randomized stimulus against the reference model
    for (int i = 0; i < 400; i++) step(rand_in());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
